// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
//   Bundle of board-side inputs and datapath-side strobes around the stopwatch
//   control sequencer. clk and rst are not part of the bundle.
//
//   Signal summary
//     btnS       raw run/pause button, asynchronous to clk
//     sw[1:0]    raw switches: sw[0]=ADJ mode, sw[1]=SEL (1=seconds, 0=minutes)
//     running    controller is in RUNNING
//     adjusting  controller is in ADJUST
//     adj_sel    synchronised sw[1]
//     cnt_tick   1-cycle strobe: advance the counter by one second
//     adj_tick   1-cycle strobe: increment the field chosen by adj_sel
//     digit_sel  active display digit, 0..3
//     blink      1 = selected field visible, 0 = blanked
//
//   Strobe semantics: there is no valid/ready pair on this bundle. cnt_tick and
//   adj_tick are fire-and-forget single-cycle pulses; the consumer must act on
//   every cycle a strobe is high, and the producer never holds one for longer
//   than one cycle nor raises both in the same cycle.
//
//   Modports
//     master  the controller (drives the strobes, samples the raw inputs)
//     slave   the board/datapath side
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic       btnS;
    logic [1:0] sw;
    logic       running;
    logic       adjusting;
    logic       adj_sel;
    logic       cnt_tick;
    logic       adj_tick;
    logic [1:0] digit_sel;
    logic       blink;

    modport master (
        input  btnS, sw,
        output running, adjusting, adj_sel, cnt_tick, adj_tick, digit_sel, blink
    );

    modport slave (
        output btnS, sw,
        input  running, adjusting, adj_sel, cnt_tick, adj_tick, digit_sel, blink
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control and timing sequencer for the stopwatch datapath. Synchronises and
//   debounces the run/pause button, synchronises the adjust switches, runs the
//   PAUSED/RUNNING/ADJUST state machine and produces single-cycle enable
//   strobes for the BCD counter plus the digit-scan and blink timing for the
//   seven-segment display. Single clock domain.
//
//   Ports
//     clk          system clock
//     rst          asynchronous, active-high reset
//     sw_if        stopwatch_ctrl_if.master bundle (raw inputs, strobes, display)
//     dbg_state_o  current FSM state encoding (0=PAUSED, 1=RUNNING, 2=ADJUST)
//
//   Build option
//     STOPWATCH_BLINK_EN  when defined, blink toggles every BLINK_DIV cycles
//                         while in ADJUST (starting visible) and a blink
//                         counter is built. When undefined, blink is constant 1.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned ADJ_DIV   = 50_000_000,
`ifdef STOPWATCH_BLINK_EN
    parameter int unsigned BLINK_DIV = 25_000_000,
`endif
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    stopwatch_ctrl_if.master       sw_if,
    output logic [1:0]             dbg_state_o
);

    localparam int unsigned TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int unsigned AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
    localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ADJUST  = 2'd2
    } state_e;

    // Input synchronisers
    logic          btn_meta_q, btn_sync_q;
    logic [1:0]    sw_meta_q,  sw_sync_q;

    // Debounce
    logic [DW-1:0] db_cnt_q,   db_cnt_d;
    logic          db_level_q, db_level_d;
    logic          toggle_q,   toggle_d;

    // FSM
    state_e        state_q,    state_d;

    // Timing counters and strobes
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          cnt_tick_q, cnt_tick_d;
    logic [AW-1:0] adj_cnt_q,  adj_cnt_d;
    logic          adj_tick_q, adj_tick_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    digit_q,    digit_d;

    // Registered state decode
    logic          running_q,  running_d;
    logic          adjusting_q, adjusting_d;

    logic          blink_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        db_cnt_d    = '0;
        db_level_d  = db_level_q;
        toggle_d    = 1'b0;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        cnt_tick_d  = 1'b0;
        adj_cnt_d   = '0;
        adj_tick_d  = 1'b0;
        scan_cnt_d  = scan_cnt_q + SW'(1);
        digit_d     = digit_q;
        running_d   = (state_q == ST_RUNNING);
        adjusting_d = (state_q == ST_ADJUST);

        // Debounce: count only while the synchronised level disagrees with the
        // accepted level; any agreement restarts the count. Only a press
        // (accepted 0->1) produces the toggle pulse.
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = btn_sync_q;
                toggle_d   = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end

        // sw_sync_q[0] is the ADJ request and wins over a same-cycle toggle.
        case (state_q)
            ST_PAUSED: begin
                if (sw_sync_q[0])  state_d = ST_ADJUST;
                else if (toggle_q) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (sw_sync_q[0])  state_d = ST_ADJUST;
                else if (toggle_q) state_d = ST_PAUSED;
            end
            ST_ADJUST: begin
                if (!sw_sync_q[0]) state_d = ST_PAUSED;
            end
            default: state_d = ST_PAUSED;
        endcase

        // Tick counter keeps its fractional second across a pause but is
        // restarted by an adjust session.
        case (state_q)
            ST_RUNNING: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    cnt_tick_d = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            ST_ADJUST: tick_cnt_d = '0;
            default:   tick_cnt_d = tick_cnt_q;
        endcase

        // Adjust counter starts from zero on every entry, so the first
        // adj_tick lands ADJ_DIV cycles after the state change.
        if (state_q == ST_ADJUST) begin
            if (adj_cnt_q == ADJ_LAST) begin
                adj_tick_d = 1'b1;
            end else begin
                adj_cnt_d = adj_cnt_q + AW'(1);
            end
        end

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            sw_meta_q   <= 2'b00;
            sw_sync_q   <= 2'b00;
            db_cnt_q    <= '0;
            db_level_q  <= 1'b0;
            toggle_q    <= 1'b0;
            state_q     <= ST_PAUSED;
            tick_cnt_q  <= '0;
            cnt_tick_q  <= 1'b0;
            adj_cnt_q   <= '0;
            adj_tick_q  <= 1'b0;
            scan_cnt_q  <= '0;
            digit_q     <= 2'd0;
            running_q   <= 1'b0;
            adjusting_q <= 1'b0;
        end else begin
            btn_meta_q  <= sw_if.btnS;
            btn_sync_q  <= btn_meta_q;
            sw_meta_q   <= sw_if.sw;
            sw_sync_q   <= sw_meta_q;
            db_cnt_q    <= db_cnt_d;
            db_level_q  <= db_level_d;
            toggle_q    <= toggle_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            cnt_tick_q  <= cnt_tick_d;
            adj_cnt_q   <= adj_cnt_d;
            adj_tick_q  <= adj_tick_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            running_q   <= running_d;
            adjusting_q <= adjusting_d;
        end
    end

    // -------------------------------------------------------------------------
    // Blink generator
    // -------------------------------------------------------------------------
`ifdef STOPWATCH_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_d;

    // Outside ADJUST the field is forced visible and the counter parked at 0,
    // so every adjust session starts with a full visible half-period.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b1;
        if (state_q == ST_ADJUST) begin
            blink_d = blink_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end
`else
    assign blink_q = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sw_if.running   = running_q;
    assign sw_if.adjusting = adjusting_q;
    assign sw_if.adj_sel   = sw_sync_q[1];
    assign sw_if.cnt_tick  = cnt_tick_q;
    assign sw_if.adj_tick  = adj_tick_q;
    assign sw_if.digit_sel = digit_q;
    assign sw_if.blink     = blink_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with small dividers. A behavioural
//   model (delay queues, accumulated run time, time-in-adjust, free cycle
//   count) predicts every output each cycle; a table of phases and a few
//   hand-written sequences check the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam int AD = 5;
`ifdef STOPWATCH_BLINK_EN
  localparam int BD = 3;
`endif
  localparam int SD = 4;
  localparam int DB = 4;
  localparam int W  = 8;

  localparam int M_PAUSED = 0;
  localparam int M_RUN    = 1;
  localparam int M_ADJ    = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  stopwatch_ctrl_if sif();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  stopwatch_ctrl #(
    .TICK_DIV (TD),
    .ADJ_DIV  (AD),
`ifdef STOPWATCH_BLINK_EN
    .BLINK_DIV(BD),
`endif
    .SCAN_DIV (SD),
    .DB_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_if      (sif),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  bit       m_btn_dl[$];
  bit [1:0] m_sw_dl[$];
  int m_cyc, m_state, m_level, m_differ, m_toggle, m_run_acc, m_adj_cyc;

  function automatic void model_reset();
    m_btn_dl  = '{1'b0, 1'b0};
    m_sw_dl   = '{2'b00, 2'b00};
    m_cyc     = 0;
    m_state   = M_PAUSED;
    m_level   = 0;
    m_differ  = 0;
    m_toggle  = 0;
    m_run_acc = 0;
    m_adj_cyc = 0;
  endfunction

  // One clock edge, given the raw inputs that were present before it.
  function automatic void model_edge(bit btn_in, bit [1:0] sw_in);
    bit       sb;
    bit [1:0] ssw;
    int       s, nxt, new_tog;
    bit       ct, at, bl;
    logic [W-1:0] e;
    sb  = m_btn_dl[0];
    ssw = m_sw_dl[0];
    s   = m_state;
    void'(m_btn_dl.pop_front());
    m_btn_dl.push_back(btn_in);
    void'(m_sw_dl.pop_front());
    m_sw_dl.push_back(sw_in);

    // accept a new button level after DB consecutive disagreeing cycles
    new_tog = 0;
    if (int'(sb) != m_level) begin
      m_differ++;
      if (m_differ == DB) begin
        m_level  = int'(sb);
        m_differ = 0;
        new_tog  = int'(sb);
      end
    end else begin
      m_differ = 0;
    end

    nxt = s;
    if (s == M_ADJ) begin
      if (!ssw[0]) nxt = M_PAUSED;
    end else if (ssw[0]) begin
      nxt = M_ADJ;
    end else if (m_toggle != 0) begin
      nxt = (s == M_RUN) ? M_PAUSED : M_RUN;
    end

    // a second elapses after every TD accumulated running cycles
    ct = 1'b0;
    if (s == M_RUN) begin
      m_run_acc++;
      ct = ((m_run_acc % TD) == 0);
    end else if (s == M_ADJ) begin
      m_run_acc = 0;
    end

    at = 1'b0;
    bl = 1'b1;
    if (s == M_ADJ) begin
      m_adj_cyc++;
      at = ((m_adj_cyc % AD) == 0);
`ifdef STOPWATCH_BLINK_EN
      bl = (((m_adj_cyc / BD) % 2) == 0);
`endif
    end else begin
      m_adj_cyc = 0;
    end

    m_cyc++;
    e = {(s == M_RUN), (s == M_ADJ), m_sw_dl[0][1], ct, at, 2'((m_cyc / SD) % 4), bl};
    exp_q.push_back(e);
    m_toggle = new_tog;
    m_state  = nxt;
  endfunction

  // ---------------- checks ----------------
  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_cycle();
    logic [W-1:0] act, expv;
    act = {sif.running, sif.adjusting, sif.adj_sel, sif.cnt_tick, sif.adj_tick,
           sif.digit_sel, sif.blink};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty at cycle %0d: got %b expected <none>", m_cyc, act);
    end else begin
      expv = exp_q.pop_front();
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle_%0d {run,adj,sel,ctick,atick,digit,blink}: got %b expected %b",
                 m_cyc, act, expv);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1 model_edge(sif.btnS, sif.sw);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    // asynchronous: outputs are back at reset values before any clock edge
    chk("reset_outputs", int'({sif.running, sif.adjusting, sif.adj_sel, sif.cnt_tick,
                               sif.adj_tick, sif.digit_sel, sif.blink}), 1);
    chk("reset_state", int'(dbg_state), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sif.btnS = 1'b0;
    sif.sw   = 2'b00;
    rst      = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // press and hold until RUNNING is reported, then release and let it settle
  task automatic press_to_run(string name);
    int lat;
    lat = 0;
    sif.btnS = 1'b1;
    while (sif.running !== 1'b1 && lat < 16) begin
      step();
      lat++;
    end
    n_cmp++;
    if (sif.running !== 1'b1 || lat > 2 + DB + 2) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles expected <= %0d", name, lat, 2 + DB + 2);
    end
    run_steps(4);
    sif.btnS = 1'b0;
    run_steps(10);
  endtask

  // ---------------- phase table ----------------
  typedef struct {
    bit       btn;
    bit [1:0] sw;
    int       cycles;
    bit       exp_run;
    bit       exp_adj;
  } phase_t;

  phase_t tbl[14];

  // ---------------- main test ----------------
  initial begin
    int strobes, h, n, idx, first_adj, second_adj, ticks_in_adj;
    bit got;

    rst      = 1'b1;
    sif.btnS = 1'b0;
    sif.sw   = 2'b00;
    @(negedge clk);

    tbl[0]  = '{1'b0, 2'b00, 10, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 20, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 30, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 20, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 15, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 10, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 2'b01, 20, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 2'b01, 10, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'b11, 10, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 10, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 20, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 15, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 10, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'b00, 10, 1'b0, 1'b0};

    // Reset, then 100 idle cycles: no strobes, digit scan 0,1,2,3,0 every 4
    do_reset();
    strobes = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      strobes += int'(sif.cnt_tick) + int'(sif.adj_tick);
      if (k == 3)  chk("digit_step0", int'(sif.digit_sel), 0);
      if (k == 7)  chk("digit_step1", int'(sif.digit_sel), 1);
      if (k == 11) chk("digit_step2", int'(sif.digit_sel), 2);
      if (k == 15) chk("digit_step3", int'(sif.digit_sel), 3);
      if (k == 19) chk("digit_wrap",  int'(sif.digit_sel), 0);
    end
    chk("idle_strobes", strobes, 0);

    // Bounce: a 2-cycle-period chatter never survives the debounce window
    for (int i = 0; i < 10; i++) begin
      sif.btnS = ~sif.btnS;
      run_steps(2);
    end
    sif.btnS = 1'b0;
    run_steps(10);
    chk("bounce_running", int'(sif.running), 0);
    chk("bounce_state", int'(dbg_state), M_PAUSED);

    // Phase table
    for (int p = 0; p < 14; p++) begin
      sif.btnS = tbl[p].btn;
      sif.sw   = tbl[p].sw;
      run_steps(tbl[p].cycles);
      chk($sformatf("phase%0d_running", p), int'(sif.running), int'(tbl[p].exp_run));
      chk($sformatf("phase%0d_adjusting", p), int'(sif.adjusting), int'(tbl[p].exp_adj));
    end

    // Pause at a known fractional second, then resume
    press_to_run("run");
    got = 1'b0;
    for (int i = 0; i < 2 * TD && !got; i++) begin
      step();
      got = sif.cnt_tick;
    end
    chk("run_tick_seen", int'(got), 1);
    run_steps(TD - 1);
    sif.btnS = 1'b1;
    h = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sif.cnt_tick) h = 0;
      else if (sif.running) h++;
    end
    sif.btnS = 1'b0;
    chk("pause_running", int'(sif.running), 0);
    chk("pause_held_count", h, 6);
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      strobes += int'(sif.cnt_tick);
    end
    chk("paused_no_ticks", strobes, 0);
    sif.btnS = 1'b1;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (sif.running) n++;
      got = sif.cnt_tick;
    end
    chk("resume_tick_seen", int'(got), 1);
    chk("resume_tick_running_cycles", n, TD - h);
    run_steps(4);
    sif.btnS = 1'b0;
    run_steps(10);

    // Adjust while running: counter stops, adj_tick every AD, button ignored
    sif.sw = 2'b01;
    idx = 0;
    first_adj = 0;
    second_adj = 0;
    ticks_in_adj = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sif.adjusting) begin
        idx++;
        ticks_in_adj += int'(sif.cnt_tick);
        if (sif.adj_tick && first_adj == 0) first_adj = idx;
        else if (sif.adj_tick && second_adj == 0) second_adj = idx;
      end
    end
    chk("adj_first_tick", first_adj, AD);
    chk("adj_tick_period", second_adj - first_adj, AD);
    chk("adj_no_cnt_tick", ticks_in_adj, 0);
    sif.btnS = 1'b1;
    run_steps(12);
    sif.btnS = 1'b0;
    run_steps(12);
    chk("adj_press_ignored", int'(sif.adjusting), 1);
    sif.sw = 2'b00;
    run_steps(6);
    chk("adj_exit_paused", int'(dbg_state), M_PAUSED);
    chk("adj_exit_running", int'(sif.running), 0);

    // Randomised segments against the model
    for (int seg = 0; seg < 250; seg++) begin
      sif.btnS  = 1'($urandom_range(0, 1));
      sif.sw[0] = ($urandom_range(0, 3) == 0);
      sif.sw[1] = 1'($urandom_range(0, 1));
      run_steps($urandom_range(1, 12));
    end
    sif.btnS = 1'b0;
    sif.sw   = 2'b00;
    run_steps(12);

    // Reset in the middle of a run
    press_to_run("rerun");
    run_steps(3);
    chk("pre_reset_running", int'(sif.running), 1);
    do_reset();
    run_steps(20);
    chk("post_reset_state", int'(dbg_state), M_PAUSED);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
